// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared single-precision constants and pipeline stage record.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int EXT_W  = 28;
    localparam int LZC_W  = 5;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    // mant layout: [27] overflow, [26] hidden, [25:3] fraction, [2:0] guard/round/sticky
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [EXT_W-1:0]  mant;
        logic              special;
        logic [31:0]       special_val;
        logic              valid;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/lzc28.sv
`default_nettype none
// ============================================================================
// Module      : lzc28
// Description : Leading-zero counter for a 28-bit word, with all-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lzc28
    import fpu_pkg::*;
(
    input  logic [EXT_W-1:0] i_value,
    output logic [LZC_W-1:0] o_count,
    output logic             o_zero
);

    // Scanning upward lets the highest set bit write last.
    always_comb begin
        o_count = LZC_W'(EXT_W);
        for (int i = 0; i < EXT_W; i++) begin
            if (i_value[i]) begin
                o_count = LZC_W'(EXT_W - 1 - i);
            end
        end
    end

    assign o_zero = (i_value == '0);

endmodule
`default_nettype wire

// File: rtl/fsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fsub_pipe
// Description : 3-stage IEEE-754 single subtractor (op1 - op2), RNE, FTZ.
// Revision    : 1.0 - initial release
// ============================================================================
module fsub_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] result,
    output logic        out_valid
);

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, order by magnitude, align
    // ------------------------------------------------------------------
    logic              w_a_sign, w_b_sign;
    logic [EXP_W-1:0]  w_a_exp, w_b_exp;
    logic [FRAC_W-1:0] w_a_frac, w_b_frac;
    logic              w_a_zero, w_b_zero;
    logic              w_a_nan, w_b_nan;
    logic              w_a_inf, w_b_inf;

    assign w_a_sign = op1[31];
    assign w_b_sign = ~op2[31];
    assign w_a_exp  = op1[30:23];
    assign w_b_exp  = op2[30:23];
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_frac = w_a_zero ? '0 : op1[22:0];
    assign w_b_frac = w_b_zero ? '0 : op2[22:0];
    assign w_a_nan  = (w_a_exp == '1) && (op1[22:0] != '0);
    assign w_b_nan  = (w_b_exp == '1) && (op2[22:0] != '0);
    assign w_a_inf  = (w_a_exp == '1) && (op1[22:0] == '0);
    assign w_b_inf  = (w_b_exp == '1) && (op2[22:0] == '0);

    logic              w_swap;
    logic              w_l_sign;
    logic [EXP_W-1:0]  w_l_exp, w_s_exp, w_exp_diff;
    logic [FRAC_W-1:0] w_l_frac, w_s_frac;
    logic              w_l_zero, w_s_zero;
    logic [EXT_W-1:0]  w_l_ext, w_s_ext, w_s_shift, w_s_aligned;
    logic              w_s_lost;

    assign w_swap     = {w_b_exp, w_b_frac} > {w_a_exp, w_a_frac};
    assign w_l_sign   = w_swap ? w_b_sign : w_a_sign;
    assign w_l_exp    = w_swap ? w_b_exp  : w_a_exp;
    assign w_s_exp    = w_swap ? w_a_exp  : w_b_exp;
    assign w_l_frac   = w_swap ? w_b_frac : w_a_frac;
    assign w_s_frac   = w_swap ? w_a_frac : w_b_frac;
    assign w_l_zero   = w_swap ? w_b_zero : w_a_zero;
    assign w_s_zero   = w_swap ? w_a_zero : w_b_zero;
    assign w_l_ext    = {1'b0, ~w_l_zero, w_l_frac, 3'b000};
    assign w_s_ext    = {1'b0, ~w_s_zero, w_s_frac, 3'b000};
    assign w_exp_diff = w_l_exp - w_s_exp;

    always_comb begin
        w_s_shift   = w_s_ext >> w_exp_diff[4:0];
        w_s_lost    = |(w_s_ext & ~({EXT_W{1'b1}} << w_exp_diff[4:0]));
        w_s_aligned = {w_s_shift[EXT_W-1:1], w_s_shift[0] | w_s_lost};
        if (w_exp_diff >= 8'd27) begin
            w_s_aligned = {27'd0, |w_s_ext};
        end
    end

    logic        w_special;
    logic [31:0] w_special_val;

    always_comb begin
        w_special     = 1'b1;
        w_special_val = QNAN;
        if (w_a_nan || w_b_nan) begin
            w_special_val = QNAN;
        end else if (w_a_inf && w_b_inf) begin
            w_special_val = (w_a_sign != w_b_sign) ? QNAN
                          : (w_a_sign ? NEG_INF : POS_INF);
        end else if (w_a_inf) begin
            w_special_val = w_a_sign ? NEG_INF : POS_INF;
        end else if (w_b_inf) begin
            w_special_val = w_b_sign ? NEG_INF : POS_INF;
        end else if (w_a_zero && w_b_zero) begin
            // Only -0 + -0 keeps a negative sign under round-to-nearest.
            w_special_val = {w_a_sign & w_b_sign, 31'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    stage_t           w_s1_next;
    stage_t           r_s1;
    logic [EXT_W-1:0] r_s1_small;
    logic             r_s1_sub;

    always_comb begin
        w_s1_next             = '0;
        w_s1_next.sign        = w_l_sign;
        w_s1_next.exp         = w_l_exp;
        w_s1_next.mant        = w_l_ext;
        w_s1_next.special     = w_special;
        w_s1_next.special_val = w_special_val;
        w_s1_next.valid       = in_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= '0;
            r_s1_small <= '0;
            r_s1_sub   <= 1'b0;
        end else if (enable) begin
            r_s1       <= w_s1_next;
            r_s1_small <= w_s_aligned;
            r_s1_sub   <= w_a_sign ^ w_b_sign;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: effective add/subtract and leading-zero count
    // ------------------------------------------------------------------
    logic [EXT_W-1:0] w_sum;
    logic [LZC_W-1:0] w_lzc;
    logic             w_sum_zero;
    stage_t           w_s2_next;
    stage_t           r_s2;
    logic [LZC_W-1:0] r_s2_lzc;
    logic             r_s2_zero;

    assign w_sum = r_s1_sub ? (r_s1.mant - r_s1_small) : (r_s1.mant + r_s1_small);

    lzc28 u_lzc (
        .i_value (w_sum),
        .o_count (w_lzc),
        .o_zero  (w_sum_zero)
    );

    always_comb begin
        w_s2_next      = r_s1;
        w_s2_next.mant = w_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2      <= '0;
            r_s2_lzc  <= '0;
            r_s2_zero <= 1'b0;
        end else if (enable) begin
            r_s2      <= w_s2_next;
            r_s2_lzc  <= w_lzc;
            r_s2_zero <= w_sum_zero;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round to nearest even, pack
    // ------------------------------------------------------------------
    logic [LZC_W-1:0]  w_lshift;
    logic [26:0]       w_norm;
    logic [9:0]        w_exp_n, w_exp_r;
    logic              w_round_up;
    logic [24:0]       w_mant_r;
    logic [FRAC_W-1:0] w_frac_out;
    logic [31:0]       w_s3_result;

    assign w_lshift = r_s2_lzc - 5'd1;

    always_comb begin
        // Bit 26 of w_norm holds the leading one; [2:0] are guard/round/sticky.
        if (r_s2.mant[27]) begin
            w_norm = {r_s2.mant[27:2], r_s2.mant[1] | r_s2.mant[0]};
        end else begin
            w_norm = r_s2.mant[26:0] << w_lshift;
        end
    end

    assign w_exp_n    = {2'b00, r_s2.exp} + 10'd1 - {5'd0, r_s2_lzc};
    assign w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_mant_r   = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
    assign w_exp_r    = w_exp_n + {9'd0, w_mant_r[24]};
    assign w_frac_out = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];

    always_comb begin
        w_s3_result = {r_s2.sign, w_exp_r[7:0], w_frac_out};
        if (r_s2.special) begin
            w_s3_result = r_s2.special_val;
        end else if (r_s2_zero) begin
            w_s3_result = 32'h0000_0000;
        end else if (w_exp_n[9] || (w_exp_n == 10'd0)) begin
            w_s3_result = {r_s2.sign, 31'd0};
        end else if (w_exp_r >= 10'd255) begin
            w_s3_result = r_s2.sign ? NEG_INF : POS_INF;
        end
    end

    logic [31:0] r_result;
    logic        r_out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (enable) begin
            r_out_valid <= r_s2.valid;
            if (r_s2.valid) begin
                r_result <= w_s3_result;
            end
        end
    end

    assign result    = r_result;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: doc/fsub_pipe.md
FSUB_PIPE -- requirements
Module: fsub_pipe

Interface
REQ-001 Parameters SHALL be none; latency and format are fixed.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  pipeline advance; low = every stage holds.
REQ-005 in_valid  input  1  op1/op2 carry an operation this cycle.
REQ-006 op1  input  32  IEEE-754 single minuend.
REQ-007 op2  input  32  IEEE-754 single subtrahend.
REQ-008 result  output  32  IEEE-754 single, op1 - op2.
REQ-009 out_valid  output  1  result is valid this cycle.

Function
REQ-010 The block SHALL compute op1 - op2 with round-to-nearest-even, treating op1 + (op2 with sign inverted) as an effective add or subtract.
REQ-011 Latency SHALL be exactly 3 enabled cycles: in_valid sampled at edge N with enable high produces out_valid at edge N+3 if enable is high at N+1..N+2.
REQ-012 Throughput SHALL be one operation per enabled cycle, with a valid bit per stage.
REQ-013 When enable is low, all stage registers, result and out_valid SHALL hold their values.
REQ-014 Stage 1 SHALL select the larger magnitude by {exp,mantissa} compare, then right-align the smaller mantissa into 28 bits (2 overflow/hidden bits, 23 fraction bits, guard, round, sticky).
REQ-015 In stage 1, an exponent difference >= 27 SHALL reduce the aligned smaller operand to sticky-only ({27'd0, nonzero}).
REQ-016 Stage 2 SHALL add or subtract the aligned mantissas and register the 28-bit sum and its leading-zero count.
REQ-017 Stage 3 SHALL normalise by the registered count, apply round-to-nearest-even from guard/round/sticky, renormalise on mantissa carry-out, and pack the result.
REQ-018 Inputs with exp==0 SHALL be treated as signed zero (flush-to-zero).
REQ-019 A normalised exponent <= 0 SHALL produce signed zero with the sign of the larger operand.
REQ-020 An exact-zero difference SHALL produce +0 (0x00000000), including x - x and +0 - +0.
REQ-021 -0 - +0 SHALL produce 0x80000000.
REQ-022 A rounded exponent >= 255 SHALL produce signed infinity (0x7F800000 / 0xFF800000).
REQ-023 A NaN on either input, or inf - inf with the same sign, SHALL produce 0x7FC00000.
REQ-024 A single infinite operand SHALL pass through as infinity, with the sign inverted if it is op2.
REQ-025 Special-case flags SHALL be computed in stage 1 and carried in the pipeline, overriding the stage-3 pack.
REQ-026 result SHALL be updated only when the stage-3 valid bit is set and SHALL otherwise hold its last value.

Reset
REQ-027 While reset is high at a clock edge, all valid bits, out_valid and result (0x00000000) SHALL clear, regardless of enable.
REQ-028 Operations in flight when reset asserts SHALL be discarded, and no out_valid SHALL appear for them.
REQ-029 The first operation accepted after reset deasserts SHALL emerge exactly 3 enabled cycles later.

Structure
REQ-030 Package fpu_pkg SHALL hold the shared constants: EXP_W=8, FRAC_W=23, EXT_W=28, QNAN=32'h7FC00000, POS_INF, NEG_INF.
REQ-031 Package fpu_pkg SHALL also hold the packed struct type for stage-1 and stage-2 registers {sign, exp, mant, special, special_val, valid}.
REQ-032 Leading-zero counting SHALL be a separate sub-module lzc28 (28-bit in, 5-bit count, all-zero flag), instantiated in stage 2.

Verification
REQ-033 Basic subtract: 0x40400000 - 0x3F800000, in_valid=1 -> 3 cycles later result=0x40000000, out_valid=1.
REQ-034 Cancellation and exact zero: 0x3F800000 - 0x3F800000 -> 0x00000000; 0x3F800000 - 0x33800000 -> 0x3F7FFFFF.
REQ-035 Tie-to-even: 0x3F800000 - 0xB3800000 -> 0x3F800000; 0x3F800001 - 0xB3800000 -> 0x3F800002.
REQ-036 Specials: 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000; 0x7F800000 - 0x7F800000 -> 0x7FC00000; 0x00400000 - 0x00000000 -> 0x00000000.
REQ-037 Stall: issue 3 back-to-back operations and hold enable low 2 cycles mid-flight -> result and out_valid are frozen, then the 3 results appear in order with no loss or duplication.
REQ-038 Reset mid-flight: assert reset 1 cycle with 2 operations in flight -> out_valid stays 0 and result=0x00000000 until a new operation completes 3 cycles after issue.
